// File: rtl/seg_pkg.sv
// Shared glyph codes, 7-segment decoder and rate helpers for the scanned display drivers.
package seg_pkg;

    localparam int G_0     = 0;
    localparam int G_1     = 1;
    localparam int G_2     = 2;
    localparam int G_3     = 3;
    localparam int G_4     = 4;
    localparam int G_5     = 5;
    localparam int G_6     = 6;
    localparam int G_7     = 7;
    localparam int G_8     = 8;
    localparam int G_9     = 9;
    localparam int G_A     = 10;
    localparam int G_B     = 11;
    localparam int G_C     = 12;
    localparam int G_D     = 13;
    localparam int G_E     = 14;
    localparam int G_F     = 15;
    localparam int G_H     = 16;
    localparam int G_L     = 17;
    localparam int G_O     = 18;
    localparam int G_R     = 19;
    localparam int G_T     = 20;
    localparam int G_U_LO  = 21;
    localparam int G_N_LO  = 22;
    localparam int G_N     = 23;
    localparam int G_U     = 24;
    localparam int G_BLANK = 31;

    function automatic int rate_ticks(input int clk_hz, input int rate_hz);
        return clk_hz / rate_hz;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Segment order {a,b,c,d,e,f,g}, segment a in the MSB; unknown codes are blank.
    function automatic logic [6:0] glyph(input int code);
        case (code)
            G_0:     glyph = 7'b1111110;
            G_1:     glyph = 7'b0110000;
            G_2:     glyph = 7'b1101101;
            G_3:     glyph = 7'b1111001;
            G_4:     glyph = 7'b0110011;
            G_5:     glyph = 7'b1011011;
            G_6:     glyph = 7'b1011111;
            G_7:     glyph = 7'b1110000;
            G_8:     glyph = 7'b1111111;
            G_9:     glyph = 7'b1111011;
            G_A:     glyph = 7'b1110111;
            G_B:     glyph = 7'b0011111;
            G_C:     glyph = 7'b1001110;
            G_D:     glyph = 7'b0111101;
            G_E:     glyph = 7'b1001111;
            G_F:     glyph = 7'b1000111;
            G_H:     glyph = 7'b0110111;
            G_L:     glyph = 7'b0001110;
            G_O:     glyph = 7'b0011101;
            G_R:     glyph = 7'b0000101;
            G_T:     glyph = 7'b0001111;
            G_U_LO:  glyph = 7'b0011100;
            G_N_LO:  glyph = 7'b0010101;
            G_N:     glyph = 7'b1110110;
            G_U:     glyph = 7'b0111110;
            G_BLANK: glyph = 7'b0000000;
            default: glyph = 7'b0000000;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter, digit index and frame-boundary strobe for time-multiplexed displays.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int TICKS  = 100_000,
    parameter int SLOT_W = cnt_width(TICKS),
    parameter int IDX_W  = cnt_width(DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [SLOT_W-1:0] slot,
    output logic [IDX_W-1:0]  idx,
    output logic              frame_done
);

    logic slot_wrap;
    logic idx_last;

    assign slot_wrap  = (slot == SLOT_W'(TICKS - 1));
    assign idx_last   = (idx == IDX_W'(DIGITS - 1));
    // High for the whole last cycle of the last digit's slot: that cycle is the frame boundary.
    assign frame_done = slot_wrap && idx_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
            idx  <= '0;
        end else if (slot_wrap) begin
            slot <= '0;
            idx  <= idx_last ? '0 : idx + 1'b1;
        end else begin
            slot <= slot + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: shared glyph decode, blink and guard masking,
// and a double-buffered frame that only swaps at the frame boundary.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int CODE_W   = 5,
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2,
    parameter int GUARD    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIGITS*CODE_W-1:0] codes,
    input  logic [DIGITS-1:0]        en_mask,
    input  logic [DIGITS-1:0]        dp_mask,
    input  logic [DIGITS-1:0]        blink_mask,
    input  logic                     load,
    output logic                     pending,
    output logic                     frame_done,
    output logic [7:0]               seg_out,
    output logic [DIGITS-1:0]        dig_sel
);

    localparam int TICKS       = rate_ticks(CLK_HZ, SCAN_HZ);
    localparam int BLINK_TICKS = rate_ticks(CLK_HZ, 2 * BLINK_HZ);
    localparam int SLOT_W      = cnt_width(TICKS);
    localparam int IDX_W       = cnt_width(DIGITS);
    localparam int BLINK_W     = cnt_width(BLINK_TICKS);

    logic [SLOT_W-1:0] slot;
    logic [IDX_W-1:0]  idx;

    seg_scan_timer #(
        .DIGITS (DIGITS),
        .TICKS  (TICKS),
        .SLOT_W (SLOT_W),
        .IDX_W  (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot       (slot),
        .idx        (idx),
        .frame_done (frame_done)
    );

    logic [DIGITS*CODE_W-1:0] sh_codes, act_codes;
    logic [DIGITS-1:0]        sh_en, sh_dp, sh_blink;
    logic [DIGITS-1:0]        act_en, act_dp, act_blink;

    // load is a one-cycle strobe with no back-pressure: every strobe is accepted
    // into the shadow, and a strobe on the boundary cycle bypasses it entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_codes  <= '0;
            sh_en     <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
            act_codes <= '0;
            act_en    <= '0;
            act_dp    <= '0;
            act_blink <= '0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                sh_codes <= codes;
                sh_en    <= en_mask;
                sh_dp    <= dp_mask;
                sh_blink <= blink_mask;
            end
            if (frame_done) begin
                pending <= 1'b0;
                if (load) begin
                    act_codes <= codes;
                    act_en    <= en_mask;
                    act_dp    <= dp_mask;
                    act_blink <= blink_mask;
                end else if (pending) begin
                    act_codes <= sh_codes;
                    act_en    <= sh_en;
                    act_dp    <= sh_dp;
                    act_blink <= sh_blink;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Free-running blink timebase, deliberately unrelated to the scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    logic [CODE_W-1:0] cur_code;
    logic              lit;
    logic [7:0]        seg_d;
    logic [DIGITS-1:0] sel_d;

    always_comb begin
        cur_code = act_codes[idx*CODE_W +: CODE_W];
        lit      = act_en[idx] && !(act_blink[idx] && blink_phase) && (slot >= SLOT_W'(GUARD));
        seg_d    = '0;
        sel_d    = '0;
        if (lit) begin
            seg_d = {glyph(int'(cur_code)), act_dp[idx]};
            sel_d = DIGITS'(1) << idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= '0;
            dig_sel <= '0;
        end else begin
            seg_out <= seg_d;
            dig_sel <= sel_d;
        end
    end

endmodule
